// File: rtl/pc_stack_pkg.sv
// Shared constants and next-PC select encoding for the PC / return-address stack.
package pc_stack_pkg;
  localparam int PC_W_DEF = 8;

  typedef enum logic [1:0] {
    SEL_INC,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET
  } sel_e;
endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses. Define PC_STACK_WRAP_EN to make it circular
// (a push when full overwrites the oldest entry instead of being refused).
module ret_stack
  import pc_stack_pkg::*;
#(
  parameter  int W     = PC_W_DEF,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return (p == '0) ? AW'(DEPTH - 1) : p - 1'b1;
  endfunction

  assign full  = (depth_q == DW'(DEPTH));
  assign empty = (depth_q == '0);
  assign depth = depth_q;
  // wp_q points at the next free slot, so the top is one behind it (mod DEPTH)
  assign top   = mem_q[ptr_dec(wp_q)];

`ifdef PC_STACK_WRAP_EN
  assign do_push = push;
`else
  assign do_push = push & ~full;
`endif
  assign do_pop = pop & ~push & ~empty;

  always_comb begin
    wp_d    = wp_q;
    depth_d = depth_q;
    if (do_push) begin
      wp_d = ptr_inc(wp_q);
      if (!full) depth_d = depth_q + 1'b1;
    end else if (do_pop) begin
      wp_d    = ptr_dec(wp_q);
      depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q    <= '0;
      depth_q <= '0;
    end else begin
      wp_q    <= wp_d;
      depth_q <= depth_d;
    end
  end

  // Storage is deliberately left uninitialised on reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/pc_stack.sv
// Program counter with call/return stack and sticky fault flags.
// Build option: PC_STACK_WRAP_EN makes the return stack circular (no overflow).
module pc_stack
  import pc_stack_pkg::*;
#(
  parameter  int PC_W     = PC_W_DEF,
  parameter  int DEPTH    = 4,
  parameter  int RESET_PC = 0,
  localparam int DW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            stack_up,
  input  logic            stack_down,
  input  logic            c_stack,
  output logic [PC_W-1:0] pc,
  output logic [DW-1:0]   depth,
  output logic            overflow,
  output logic            underflow,
  output logic            conflict
);
`ifdef PC_STACK_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic [PC_W-1:0] pc_q, pc_d, pc_inc, stk_top;
  logic            ovf_q, ovf_d, udf_q, udf_d, cfl_q, cfl_d;
  logic            stk_full, stk_empty, ret_req;
  sel_e            sel;

  assign pc_inc  = pc_q + 1'b1;
  assign ret_req = stack_down & c_stack;

  always_comb begin
    sel = SEL_INC;
    if (stack_up)                  sel = SEL_CALL;
    else if (ret_req && !stk_empty) sel = SEL_RET;
    else if (ret_req)              sel = SEL_INC;   // empty return degrades to INC
    else if (jump)                 sel = SEL_JUMP;
  end

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      unique case (sel)
        SEL_CALL, SEL_JUMP: pc_d = jump_addr;
        SEL_RET:            pc_d = stk_top;
        default:            pc_d = pc_inc;
      endcase
    end
  end

  assign ovf_d = ovf_q | (en & stack_up & stk_full & ~WRAP_EN);
  assign udf_d = udf_q | (en & ~stack_up & ret_req & stk_empty);
  assign cfl_d = cfl_q | (en & stack_up & stack_down);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= PC_W'(RESET_PC);
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      cfl_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      cfl_q <= cfl_d;
    end
  end

  ret_stack #(.W(PC_W), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (en && sel == SEL_CALL),
    .pop   (en && sel == SEL_RET),
    .din   (pc_inc),
    .top   (stk_top),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign pc        = pc_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign conflict  = cfl_q;
endmodule

// File: tb/tb_pc_stack.sv
// Directed self-checking bench for pc_stack (PC_W=8, DEPTH=4, RESET_PC=0x10).
module tb_pc_stack;
  logic       clk = 1'b0;
  logic       reset, en, jump, stack_up, stack_down, c_stack;
  logic [7:0] jump_addr;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       overflow, underflow, conflict;

  int n_checks = 0;
  int n_fail   = 0;

  pc_stack #(.PC_W(8), .DEPTH(4), .RESET_PC(8'h10)) dut (
    .clk(clk), .reset(reset), .en(en), .jump(jump), .jump_addr(jump_addr),
    .stack_up(stack_up), .stack_down(stack_down), .c_stack(c_stack),
    .pc(pc), .depth(depth), .overflow(overflow), .underflow(underflow),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [7:0] e_pc, input logic [2:0] e_dep,
                           input logic e_ovf, input logic e_udf, input logic e_cfl);
    chk({tag, ".pc"}, {8'h0, pc}, {8'h0, e_pc});
    chk({tag, ".depth"}, {13'h0, depth}, {13'h0, e_dep});
    chk({tag, ".flags"}, {13'h0, overflow, underflow, conflict}, {13'h0, e_ovf, e_udf, e_cfl});
  endtask

  // Apply one set of controls across a rising edge, sample 1 time unit later.
  task automatic step(input logic e, input logic j, input logic [7:0] a,
                      input logic up, input logic dn, input logic cs);
    en = e; jump = j; jump_addr = a; stack_up = up; stack_down = dn; c_stack = cs;
    @(posedge clk);
    #1;
    en = 1'b0; jump = 1'b0; stack_up = 1'b0; stack_down = 1'b0; c_stack = 1'b0;
  endtask

  logic ovf_exp;

  initial begin
`ifdef PC_STACK_WRAP_EN
    ovf_exp = 1'b0;
`else
    ovf_exp = 1'b1;
`endif
    reset = 1'b1; en = 0; jump = 0; jump_addr = 8'h00; stack_up = 0; stack_down = 0; c_stack = 0;
    #12;
    chk_state("reset", 8'h10, 3'd0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // plain increment
    step(1, 0, 8'h00, 0, 0, 0); chk_state("inc1", 8'h11, 0, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0); chk("inc2.pc", {8'h0, pc}, 16'h0012);
    step(1, 0, 8'h00, 0, 0, 0); chk_state("inc3", 8'h13, 0, 0, 0, 0);

    // call / return with c_stack-less stack_down falling through
    step(1, 1, 8'h20, 0, 0, 0); chk("jump.pc", {8'h0, pc}, 16'h0020);
    step(1, 0, 8'h40, 1, 0, 0); chk_state("call", 8'h40, 1, 0, 0, 0);
    step(1, 0, 8'h00, 0, 1, 0); chk_state("dn_no_cs", 8'h41, 1, 0, 0, 0);
    step(1, 0, 8'h00, 0, 0, 0); chk("inc42.pc", {8'h0, pc}, 16'h0042);
    step(1, 0, 8'h00, 0, 1, 1); chk_state("ret", 8'h21, 0, 0, 0, 0);

    // five nested calls into a 4-deep stack
    step(1, 0, 8'h80, 1, 0, 0); chk_state("nest1", 8'h80, 1, 0, 0, 0);
    step(1, 0, 8'h90, 1, 0, 0); chk_state("nest2", 8'h90, 2, 0, 0, 0);
    step(1, 0, 8'hA0, 1, 0, 0); chk_state("nest3", 8'hA0, 3, 0, 0, 0);
    step(1, 0, 8'hB0, 1, 0, 0); chk_state("nest4", 8'hB0, 4, 0, 0, 0);
    step(1, 0, 8'hC0, 1, 0, 0); chk_state("nest5", 8'hC0, 4, ovf_exp, 0, 0);
`ifdef PC_STACK_WRAP_EN
    step(1, 0, 8'h00, 0, 1, 1); chk_state("unw1", 8'hB1, 3, 0, 0, 0);
    step(1, 0, 8'h00, 0, 1, 1); chk_state("unw2", 8'hA1, 2, 0, 0, 0);
    step(1, 0, 8'h00, 0, 1, 1); chk_state("unw3", 8'h91, 1, 0, 0, 0);
    step(1, 0, 8'h00, 0, 1, 1); chk_state("unw4", 8'h81, 0, 0, 0, 0);
`else
    step(1, 0, 8'h00, 0, 1, 1); chk_state("unw1", 8'hA1, 3, 1, 0, 0);
    step(1, 0, 8'h00, 0, 1, 1); chk_state("unw2", 8'h91, 2, 1, 0, 0);
    step(1, 0, 8'h00, 0, 1, 1); chk_state("unw3", 8'h81, 1, 1, 0, 0);
    step(1, 0, 8'h00, 0, 1, 1); chk_state("unw4", 8'h22, 0, 1, 0, 0);
`endif

    // return on empty stack
    step(1, 1, 8'h33, 0, 0, 0); chk("j33.pc", {8'h0, pc}, 16'h0033);
    step(1, 0, 8'h00, 0, 1, 1); chk_state("udf", 8'h34, 0, ovf_exp, 1, 0);
    step(1, 0, 8'h00, 0, 0, 0); chk_state("udf_sticky", 8'h35, 0, ovf_exp, 1, 0);

    // wrap-around of pc+1 and of the pushed return address
    step(1, 1, 8'hFF, 0, 0, 0); chk("jff.pc", {8'h0, pc}, 16'h00FF);
    step(1, 0, 8'h00, 0, 0, 0); chk("wrap_inc.pc", {8'h0, pc}, 16'h0000);
    step(1, 1, 8'hFF, 0, 0, 0);
    step(1, 0, 8'h50, 1, 0, 0); chk_state("call_ff", 8'h50, 1, ovf_exp, 1, 0);
    step(1, 0, 8'h00, 0, 1, 1); chk_state("ret_00", 8'h00, 0, ovf_exp, 1, 0);

    // conflict: held off by en=0, then taken as CALL
    step(0, 1, 8'h70, 1, 1, 1); chk_state("hold", 8'h00, 0, ovf_exp, 1, 0);
    step(1, 0, 8'h70, 1, 1, 1); chk_state("conflict", 8'h70, 1, ovf_exp, 1, 1);

    // asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1 chk_state("async_rst", 8'h10, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 8'h00, 0, 0, 0); chk("post_rst_hold.pc", {8'h0, pc}, 16'h0010);
    step(1, 0, 8'h00, 0, 0, 0); chk_state("post_rst_inc", 8'h11, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
